// File: rtl/dispatch_pkg.sv
// dispatch_pkg: types and helpers shared by the dispatch stage.
//   - default widths for the dispatch stage parameters
//   - RS class enum, rename uop bundle, RS queue entry layouts
//   - class_credit(): free slots usable by one class in one cycle
package dispatch_pkg;

  localparam int DEF_DISPATCH_W = 2;
  localparam int DEF_CREDIT_W   = 4;
  localparam int DEF_ROB_IDX_W  = 6;
  localparam int PRF_W          = 6;

  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_LSU = 2'd1,
    RS_MDU = 2'd2
  } RSType;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } DispState;

  typedef logic [PRF_W-1:0] PRFNum;

  typedef struct packed {
    logic                     valid;
    RSType                    rs;
    logic [7:0]               op;
    logic [DEF_ROB_IDX_W-1:0] id;
    logic                     op0re;
    logic [4:0]               op0LAddr;
    PRFNum                    prs1;
    logic                     op1re;
    logic [4:0]               op1LAddr;
    PRFNum                    prs2;
    logic                     dstwe;
    PRFNum                    prd;
    logic                     isStore;
    logic                     isMul;
  } UOPBundle;

  typedef struct packed {
    logic [DEF_ROB_IDX_W-1:0] id;
    logic [7:0]               op;
    PRFNum                    prs1;
    logic                     prs1_rdy;
    PRFNum                    prs2;
    logic                     prs2_rdy;
    logic                     dstwe;
    PRFNum                    prd;
  } QueueCommon;

  typedef QueueCommon ALU_Queue_Meta;

  typedef struct packed {
    QueueCommon c;
    logic       isStore;
  } LSU_Queue_Meta;

  typedef struct packed {
    QueueCommon c;
    logic       isMul;
  } MDU_Queue_Meta;

  // MDU is limited both by its free entries and by its write-port count.
  // Unknown class encodings get no credit and simply never dispatch.
  function automatic int class_credit(RSType c, logic [DEF_CREDIT_W-1:0] alu_free,
                                      logic [DEF_CREDIT_W-1:0] lsu_free,
                                      logic [DEF_CREDIT_W-1:0] mdu_free, int mdu_ports);
    int mdu;
    mdu = (int'(mdu_free) < mdu_ports) ? int'(mdu_free) : mdu_ports;
    case (c)
      RS_ALU:  return int'(alu_free);
      RS_LSU:  return int'(lsu_free);
      RS_MDU:  return mdu;
      default: return 0;
    endcase
  endfunction

  // An operand reading x0 (or not read at all) is ready immediately.
  function automatic QueueCommon to_common(UOPBundle u);
    QueueCommon q;
    q.id       = u.id;
    q.op       = u.op;
    q.prs1     = u.prs1;
    q.prs1_rdy = ~(u.op0re && (u.op0LAddr != 5'd0));
    q.prs2     = u.prs2;
    q.prs2_rdy = ~(u.op1re && (u.op1LAddr != 5'd0));
    q.dstwe    = u.dstwe;
    q.prd      = u.prd;
    return q;
  endfunction

endpackage

// File: rtl/dispatch_select.sv
// dispatch_select: combinational oldest-first selection.
//   pend/cls              pending mask and RS class per buffered slot
//   rob_free, *_free      ROB and per-class RS credits this cycle
//   sel                   slots dispatching this cycle (an oldest-first prefix)
//   rob_off               position of each selected slot among all selected uops
//   port_idx              position of each selected slot among its own class
//   blk_rob / blk_rs      oldest pending slot blocked by ROB / RS credit
module dispatch_select
  import dispatch_pkg::*;
#(
  parameter int DISPATCH_W = DEF_DISPATCH_W,
  parameter int CREDIT_W   = DEF_CREDIT_W,
  parameter int MDU_PORTS  = 1,
  parameter int CNT_W      = 2
) (
  input  logic [DISPATCH_W-1:0]            pend,
  input  RSType [DISPATCH_W-1:0]           cls,
  input  logic [CREDIT_W-1:0]              rob_free,
  input  logic [CREDIT_W-1:0]              alu_free,
  input  logic [CREDIT_W-1:0]              lsu_free,
  input  logic [CREDIT_W-1:0]              mdu_free,
  output logic [DISPATCH_W-1:0]            sel,
  output logic [DISPATCH_W-1:0][CNT_W-1:0] rob_off,
  output logic [DISPATCH_W-1:0][CNT_W-1:0] port_idx,
  output logic                             blk_rob,
  output logic                             blk_rs
);

  int   rob_n, alu_n, lsu_n, mdu_n, used;
  logic go, first, rob_ok, rs_ok;

  // Walk the slots oldest first with running ROB and per-class counts.
  // The first pending slot that does not fit stops the walk, so no younger
  // uop can overtake it.
  always_comb begin
    sel      = '0;
    rob_off  = '0;
    port_idx = '0;
    blk_rob  = 1'b0;
    blk_rs   = 1'b0;
    rob_n    = 0;
    alu_n    = 0;
    lsu_n    = 0;
    mdu_n    = 0;
    used     = 0;
    go       = 1'b1;
    first    = 1'b1;
    rob_ok   = 1'b0;
    rs_ok    = 1'b0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      if (pend[k] && go) begin
        case (cls[k])
          RS_ALU:  used = alu_n;
          RS_LSU:  used = lsu_n;
          default: used = mdu_n;
        endcase
        rob_ok = rob_n < int'(rob_free);
        rs_ok  = used < class_credit(cls[k], alu_free, lsu_free, mdu_free, MDU_PORTS);
        if (rob_ok && rs_ok) begin
          sel[k]      = 1'b1;
          rob_off[k]  = CNT_W'(rob_n);
          port_idx[k] = CNT_W'(used);
          rob_n       = rob_n + 1;
          case (cls[k])
            RS_ALU:  alu_n = alu_n + 1;
            RS_LSU:  lsu_n = lsu_n + 1;
            default: mdu_n = mdu_n + 1;
          endcase
        end else begin
          go      = 1'b0;
          blk_rob = first && !rob_ok;
          blk_rs  = first && rob_ok && !rs_ok;
        end
        first = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dispatch_stage_nw.sv
// dispatch_stage_nw: N-wide dispatch between rename and the RS/ROB/scoreboard.
// Buffers one rename group and each cycle sends the oldest-first prefix that
// fits the credits; leftovers stay buffered, so stalls are partial.
//   clk, rst (sync, active high), flush
//   in_valid/in_uops/in_ready     rename group handshake, slot 0 oldest
//   rob_free/rob_tail_id          ROB credit and next ROB id
//   rob_wen/rob_uops              compacted ROB writes (.id filled)
//   alu_/lsu_/mdu_free            RS credits; *_wen/*_dout compacted RS writes
//   sb_wen/sb_wnum                scoreboard busy-set
// Optional macro DISPATCH_PERF_CNT_EN adds stall_rob_cnt, stall_rs_cnt, grp_cnt.
module dispatch_stage_nw
  import dispatch_pkg::*;
#(
  parameter int DISPATCH_W = DEF_DISPATCH_W,
  parameter int ROB_IDX_W  = DEF_ROB_IDX_W,
  parameter int CREDIT_W   = DEF_CREDIT_W,
  parameter int MDU_PORTS  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  input  UOPBundle [DISPATCH_W-1:0]       in_uops,
  output logic                            in_ready,
  input  logic [CREDIT_W-1:0]             rob_free,
  input  logic [ROB_IDX_W-1:0]            rob_tail_id,
  output logic [DISPATCH_W-1:0]           rob_wen,
  output UOPBundle [DISPATCH_W-1:0]       rob_uops,
  input  logic [CREDIT_W-1:0]             alu_free,
  input  logic [CREDIT_W-1:0]             lsu_free,
  input  logic [CREDIT_W-1:0]             mdu_free,
  output logic [DISPATCH_W-1:0]           alu_wen,
  output logic [DISPATCH_W-1:0]           lsu_wen,
  output logic [MDU_PORTS-1:0]            mdu_wen,
  output ALU_Queue_Meta [DISPATCH_W-1:0]  alu_dout,
  output LSU_Queue_Meta [DISPATCH_W-1:0]  lsu_dout,
  output MDU_Queue_Meta [MDU_PORTS-1:0]   mdu_dout,
  output logic [DISPATCH_W-1:0]           sb_wen,
  output PRFNum [DISPATCH_W-1:0]          sb_wnum
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]                     stall_rob_cnt,
  output logic [31:0]                     stall_rs_cnt,
  output logic [31:0]                     grp_cnt
`endif
);

  localparam int CNT_W = $clog2(DISPATCH_W + 1);

  DispState                        state;
  UOPBundle [DISPATCH_W-1:0]       buf_uops;
  logic [DISPATCH_W-1:0]           pend, sel, fire, left, load_pend;
  RSType [DISPATCH_W-1:0]          cls;
  logic [DISPATCH_W-1:0][CNT_W-1:0] rob_off, port_idx;
  logic                            blk_rob, blk_rs, active, load;
  UOPBundle                        cur;
  QueueCommon                      com;

  always_comb begin
    cls       = '0;
    load_pend = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      cls[k]       = buf_uops[k].rs;
      load_pend[k] = in_uops[k].valid;
    end
  end

  dispatch_select #(
    .DISPATCH_W(DISPATCH_W),
    .CREDIT_W  (CREDIT_W),
    .MDU_PORTS (MDU_PORTS),
    .CNT_W     (CNT_W)
  ) u_select (
    .pend    (pend),
    .cls     (cls),
    .rob_free(rob_free),
    .alu_free(alu_free),
    .lsu_free(lsu_free),
    .mdu_free(mdu_free),
    .sel     (sel),
    .rob_off (rob_off),
    .port_idx(port_idx),
    .blk_rob (blk_rob),
    .blk_rs  (blk_rs)
  );

  // Nothing is written and nothing accepted in a reset or flush cycle.
  // A new group may replace the buffer on the same edge the last pending
  // slots leave, which keeps full-credit throughput at one group per cycle.
  assign active   = !rst && !flush;
  assign fire     = sel & {DISPATCH_W{active}};
  assign left     = pend & ~sel;
  assign in_ready = active && ((state == ST_EMPTY) || (left == '0));
  assign load     = in_valid && in_ready;

  // Compaction: rob_off picks the ROB/scoreboard port, port_idx picks the
  // port within the uop's own RS class, so every wen is a thermometer mask.
  always_comb begin
    rob_wen  = '0;
    rob_uops = '0;
    sb_wen   = '0;
    sb_wnum  = '0;
    alu_wen  = '0;
    lsu_wen  = '0;
    mdu_wen  = '0;
    alu_dout = '0;
    lsu_dout = '0;
    mdu_dout = '0;
    cur      = '0;
    com      = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      cur    = buf_uops[k];
      cur.id = rob_tail_id + ROB_IDX_W'(rob_off[k]);
      com    = to_common(cur);
      for (int j = 0; j < DISPATCH_W; j++) begin
        if (fire[k] && (rob_off[k] == CNT_W'(j))) begin
          rob_wen[j]  = 1'b1;
          rob_uops[j] = cur;
          sb_wen[j]   = cur.dstwe;
          sb_wnum[j]  = cur.prd;
        end
        if (fire[k] && (port_idx[k] == CNT_W'(j))) begin
          if (cur.rs == RS_ALU) begin
            alu_wen[j]  = 1'b1;
            alu_dout[j] = com;
          end else if (cur.rs == RS_LSU) begin
            lsu_wen[j]  = 1'b1;
            lsu_dout[j] = '{c: com, isStore: cur.isStore};
          end
        end
      end
      for (int j = 0; j < MDU_PORTS; j++) begin
        if (fire[k] && (cur.rs == RS_MDU) && (port_idx[k] == CNT_W'(j))) begin
          mdu_wen[j]  = 1'b1;
          mdu_dout[j] = '{c: com, isMul: cur.isMul};
        end
      end
    end
  end

  // EMPTY/HOLD state with the pending mask; a group with no valid slot
  // leaves the stage EMPTY. The buffer payload itself needs no reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= ST_EMPTY;
      pend  <= '0;
    end else if (load) begin
      buf_uops <= in_uops;
      pend     <= load_pend;
      state    <= (|load_pend) ? ST_HOLD : ST_EMPTY;
    end else begin
      pend  <= left;
      state <= (|left) ? ST_HOLD : ST_EMPTY;
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_rob_cnt <= '0;
      stall_rs_cnt  <= '0;
      grp_cnt       <= '0;
    end else begin
      if (!flush && blk_rob) stall_rob_cnt <= stall_rob_cnt + 32'd1;
      if (!flush && blk_rs)  stall_rs_cnt  <= stall_rs_cnt + 32'd1;
      if (load)              grp_cnt       <= grp_cnt + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = blk_rob | blk_rs;
`endif

endmodule

// File: doc/dispatch_stage_nw.md
Name: dispatch_stage_nw

Overview:
- Parametrised N-wide dispatch stage between rename and the reservation stations (ALU/MDU/LSU queues), ROB and scoreboard.
- Holds one rename group in a registered buffer.
- Each cycle it dispatches the oldest-first prefix of pending uops that fits in the per-class RS credits and ROB free space.
- Leftover uops are kept for later cycles, so the pipeline stalls partially instead of as a whole group.

Parameters:
DISPATCH_W, 2, uops per rename group and per-class RS write ports
ROB_IDX_W, 6, ROB index width
CREDIT_W, 4, width of the RS/ROB free-count inputs
MDU_PORTS, 1, max MDU uops dispatched per cycle (1..DISPATCH_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush (mispredict/exception)
in_valid  in  1  rename group valid
in_uops  in  UOPBundle[DISPATCH_W]  rename group, slot 0 oldest
in_ready  out  1  group accepted this cycle when in_valid&&in_ready
rob_free  in  CREDIT_W  free ROB entries
rob_tail_id  in  ROB_IDX_W  ROB id of next allocation
rob_wen  out  DISPATCH_W  compacted ROB write enables
rob_uops  out  UOPBundle[DISPATCH_W]  compacted uops, .id filled
alu_free / lsu_free / mdu_free  in  CREDIT_W each  free RS entries
alu_wen / lsu_wen  out  DISPATCH_W each  compacted RS write enables
mdu_wen  out  MDU_PORTS  compacted MDU write enables
alu_dout  out  ALU_Queue_Meta[DISPATCH_W]  ALU RS entries
lsu_dout  out  LSU_Queue_Meta[DISPATCH_W]  LSU RS entries (isStore set)
mdu_dout  out  MDU_Queue_Meta[MDU_PORTS]  MDU RS entries (isMul set)
sb_wen  out  DISPATCH_W  scoreboard busy-set enables
sb_wnum  out  PRFNum[DISPATCH_W]  PRF numbers to mark busy

Behaviour:
- State: EMPTY (no buffered group) and HOLD (buffer valid, pending mask nonzero). Buffer fields: buf_uops, pend[DISPATCH_W].
- Reset or flush puts the stage in EMPTY with pend=0. All wen outputs are 0 in the reset cycle and the flush cycle. in_ready=0 during flush.
- in_ready = EMPTY || (all pending slots dispatch this cycle). The load overwrites the buffer on the same edge as the last dispatch. This gives 1 bubble-free cycle per group at full credit.
- Load: pend[k] = in_uops[k].valid. A group with no valid slots stays EMPTY.
- Latency: a group accepted at edge t is presented to the RS/ROB in cycle t+1 (combinational from the buffer).
- Selection is oldest-first over pending slots. Slot k is selected iff:
  - every older pending slot is selected;
  - cumulative ROB count ≤ rob_free;
  - cumulative count of its class ≤ that class free count (MDU additionally ≤ MDU_PORTS).
  - Stop at the first slot that fails; no younger slot bypasses it.
- Selected slots clear pend at the edge. If pend then becomes 0, the next state is EMPTY, or reload if in_valid.
- ROB id: the j-th selected uop (j = 0..) gets id = rob_tail_id + j, modulo 2^ROB_IDX_W (wrap-around).
- Compaction: the j-th selected uop of class C drives C port j, so C_wen is a thermometer mask. ROB outputs are compacted the same way.
- Operand ready: prs1_rdy = ~(op0re && op0LAddr!=0). prs2_rdy likewise for op1.
- sb_wen[j] = selected && dstwe. sb_wnum is compacted alongside rob_uops.
- Zero credits: nothing dispatches, the state is held, and in_ready=0.

Optional Feature:
DISPATCH_PERF_CNT_EN:
- Defined: adds outputs stall_rob_cnt, stall_rs_cnt, grp_cnt (32-bit each, wrapping). They count cycles where the oldest pending slot was blocked by ROB credit or by RS credit, and accepted groups. All are cleared by rst, not by flush.
- Undefined: no ports and no logic.

Decomposition:
- Shared package dispatch_pkg: DISPATCH_W default, CREDIT_W, and a class-count helper function.
- Existing codebase types are reused: RS type enum, UOPBundle, *_Queue_Meta.
- One natural sub-module: dispatch_select. It is combinational and takes pend, classes and credits to produce the select mask, per-slot ROB offset and per-class port index.

Test Plan:
- Group {ALU, ALU}, all credits 8, rob_tail_id=5 -> next cycle alu_wen=11, ids 5 and 6, in_ready=1, state returns to EMPTY.
- Group {LSU, ALU}, lsu_free=0 -> no wen and in_ready=0. Set lsu_free=1 in the next cycle -> lsu_wen=01 and alu_wen=01 in the same cycle.
- Group {ALU, LSU}, lsu_free=0 -> slot 0 dispatches only (alu_wen=01, pend=10). Next cycle with lsu_free=1 -> LSU dispatches with id = tail+0 of that cycle.
- Group {MDU, MDU}, MDU_PORTS=1 -> dispatched over two consecutive cycles, mdu_wen=1 each cycle.
- rob_tail_id=63 (ROB_IDX_W=6), two uops -> ids 63 and 0.
- flush asserted while in HOLD -> all wen=0 that cycle, EMPTY next cycle, and the pending uop is never dispatched.
